imem_block_responder: RTL and testbench

//  Instruction-memory side of the icache refill interface. Serves 128-bit, 4-word blocks on mem_read/mem_address.

---
 rtl/imem_block_responder_pkg.sv | 26 ++
 rtl/imem_block_responder_if.sv | 25 ++
 rtl/imem_block_responder_word_array.sv | 24 ++
 rtl/imem_block_responder.sv | 138 +++++++++++++
 tb/tb_imem_block_responder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/imem_block_responder_pkg.sv
// Shared types and constants for the instruction-memory block responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BLOCK_W       = 128;
    localparam int unsigned BLK_ADDR_W    = 6;
    localparam int unsigned WORD_ADDR_W   = 8;
    localparam int unsigned WORDS_PER_BLK = 4;
    localparam int unsigned DEPTH_W       = 256;

    // Word index inside the store for a given block and beat.
    function automatic logic [WORD_ADDR_W-1:0] word_index(
        input logic [BLK_ADDR_W-1:0] blk,
        input logic [1:0]            beat
    );
        return {blk, beat};
    endfunction

endpackage

// File: rtl/imem_block_responder_if.sv
// Refill and program-write bus between the icache/loader (master) and the
// instruction-memory responder (slave).
interface imem_block_responder_if;
    import imem_pkg::*;

    logic                   mem_read;
    logic [BLK_ADDR_W-1:0]  mem_address;
    logic                   mem_busywait;
    logic [BLOCK_W-1:0]     mem_readdata;
    logic                   prog_we;
    logic [WORD_ADDR_W-1:0] prog_addr;
    logic [WORD_W-1:0]      prog_data;
    logic                   prog_ready;

    modport master (
        output mem_read, mem_address, prog_we, prog_addr, prog_data,
        input  mem_busywait, mem_readdata, prog_ready
    );

    modport slave (
        input  mem_read, mem_address, prog_we, prog_addr, prog_data,
        output mem_busywait, mem_readdata, prog_ready
    );

endinterface

// File: rtl/imem_block_responder_word_array.sv
// 256x32 program store: asynchronous read, posedge write, no reset.
module imem_word_array
    import imem_pkg::*;
(
    input  logic                   clock,
    input  logic                   we,
    input  logic [WORD_ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0]      wdata,
    input  logic [WORD_ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0]      rdata
);

    logic [WORD_W-1:0] mem [DEPTH_W];

    // Program-port write.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_block_responder.sv
// Instruction-memory responder for icache refills: assembles 4-word blocks
// from the program store after LATENCY wait cycles and holds busywait until
// the block is presented. Optional one-entry line buffer: IMEM_LINEBUF_EN.
module imem_block_responder
    import imem_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic clock,
    input  logic reset,
    imem_block_responder_if.slave bus
);

    localparam int unsigned CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY);

    state_t                 state_q, state_d;
    logic [BLK_ADDR_W-1:0]  a_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [1:0]             beat_q;
    logic [BLOCK_W-1:0]     readdata_q;
    logic [WORD_W-1:0]      rd_word;
    logic                   prog_take;
    logic                   hit;

`ifdef IMEM_LINEBUF_EN
    logic                   lb_valid_q;
    logic [BLK_ADDR_W-1:0]  lb_tag_q;
    logic [BLOCK_W-1:0]     lb_data_q;

    assign hit = lb_valid_q && (lb_tag_q == bus.mem_address);
`else
    assign hit = 1'b0;
`endif

    // Reset gating keeps both handshake outputs low while reset is held.
    assign bus.mem_busywait = reset && bus.mem_read && (state_q != DONE);
    assign bus.prog_ready   = reset && (state_q == IDLE) && !bus.mem_read;
    assign bus.mem_readdata = readdata_q;
    assign prog_take        = bus.prog_we && bus.prog_ready;

    imem_word_array u_store (
        .clock (clock),
        .we    (prog_take),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (word_index(a_q, beat_q)),
        .rdata (rd_word)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped mem_read in WAIT/FILL aborts to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_read) begin
                    if (hit)               state_d = DONE;
                    else if (LATENCY == 0) state_d = FILL;
                    else                   state_d = WAIT;
                end
            end
            WAIT: begin
                if (!bus.mem_read)                 state_d = IDLE;
                else if (cnt_q == CNT_W'(1))       state_d = FILL;
            end
            FILL: begin
                if (!bus.mem_read)                 state_d = IDLE;
                else if (beat_q == 2'd3)           state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, wait counter, beat counter and block assembly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q        <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            readdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mem_read) begin
                        a_q    <= bus.mem_address;
                        cnt_q  <= CNT_INIT;
                        beat_q <= '0;
`ifdef IMEM_LINEBUF_EN
                        if (hit) begin
                            readdata_q <= lb_data_q;
                        end
`endif
                    end
                end
                WAIT: begin
                    if (bus.mem_read) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FILL: begin
                    if (bus.mem_read) begin
                        readdata_q[WORD_W*beat_q +: WORD_W] <= rd_word;
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IMEM_LINEBUF_EN
    // Line buffer: captured on every DONE, invalidated by a write into its block.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lb_valid_q <= 1'b0;
            lb_tag_q   <= '0;
            lb_data_q  <= '0;
        end else if (state_q == DONE) begin
            lb_valid_q <= 1'b1;
            lb_tag_q   <= a_q;
            lb_data_q  <= readdata_q;
        end else if (prog_take && (bus.prog_addr[WORD_ADDR_W-1:2] == lb_tag_q)) begin
            lb_valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_imem_block_responder.sv
// Directed, table-driven bench for imem_block_responder (LATENCY=4).
module tb_imem_block_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    imem_block_responder_if bus();

    imem_block_responder #(.LATENCY(4)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]   blk;
        logic [127:0] exp_data;
        int           exp_busy;
    } vec_t;

    vec_t vt[5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Starts at posedge+1; returns at posedge+1 after the write edge.
    task automatic prog_write(input logic [7:0] addr, input logic [31:0] data);
        int n;
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        #1;
        n = 0;
        while (!bus.prog_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("prog_ready_timeout", 128'(n), 128'(0));
        @(posedge clk); #1;
        bus.prog_we = 1'b0;
    endtask

    // Starts at posedge+1; returns at posedge+2 of the same cycle.
    task automatic start_read(input logic [5:0] blk);
        bus.mem_read    = 1'b1;
        bus.mem_address = blk;
        #1;
    endtask

    // Counts busy cycles, captures data in the response cycle, ends at posedge+1.
    task automatic wait_resp(output int cycles, output logic [127:0] data);
        cycles = 0;
        while (bus.mem_busywait && cycles < 40) begin
            cycles++;
            @(posedge clk); #1;
        end
        if (cycles >= 40) check("busywait_timeout", 128'(cycles), 128'(0));
        data = bus.mem_readdata;
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int           cyc;
        logic [127:0] data;
        int           lb_busy;

`ifdef IMEM_LINEBUF_EN
        lb_busy = 1;
`else
        lb_busy = 9;
`endif

        vt[0] = '{6'h05, 128'hA0000017_A0000016_A0000015_A0000014, 9};
        vt[1] = '{6'h3F, 128'hA00000FF_A00000FE_A00000FD_A00000FC, 9};
        vt[2] = '{6'h00, 128'hA0000003_A0000002_A0000001_A0000000, 9};
        vt[3] = '{6'h02, 128'hA000000B_A000000A_A0000009_A0000008, 9};
        vt[4] = '{6'h10, 128'hA0000043_A0000042_A0000041_A0000040, 9};

        checks = 0;
        errors = 0;
        rst_n           = 1'b0;
        bus.mem_read    = 1'b1;
        bus.mem_address = 6'h05;
        bus.prog_we     = 1'b0;
        bus.prog_addr   = '0;
        bus.prog_data   = '0;

        // Reset state, with mem_read already high.
        @(posedge clk); #1;
        check("reset_busywait", 128'(bus.mem_busywait), 128'(0));
        check("reset_readdata", bus.mem_readdata, 128'h0);
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_prog_ready", 128'(bus.prog_ready), 128'(1));

        for (int i = 0; i < 256; i++) begin
            prog_write(8'(i), 32'hA000_0000 + 32'(i));
        end

        // Table of block reads.
        for (int i = 0; i < 5; i++) begin
            start_read(vt[i].blk);
            check($sformatf("busy_same_cycle_%0d", i), 128'(bus.mem_busywait), 128'(1));
            wait_resp(cyc, data);
            check($sformatf("busy_cycles_%0d", i), 128'(cyc), 128'(vt[i].exp_busy));
            check($sformatf("block_data_%0d", i), data, vt[i].exp_data);
        end

        // Abort during FILL beat 1 (cycle 6 after the request edge).
        start_read(6'h05);
        repeat (6) begin @(posedge clk); end
        #1;
        bus.mem_read = 1'b0;
        #1;
        check("abort_busywait", 128'(bus.mem_busywait), 128'(0));
        @(posedge clk); #1;
        check("abort_back_to_idle", 128'(bus.prog_ready), 128'(1));
        start_read(6'h02);
        wait_resp(cyc, data);
        check("after_abort_cycles", 128'(cyc), 128'(9));
        check("after_abort_data", data, 128'hA000000B_A000000A_A0000009_A0000008);

        // Read and write together in IDLE: read wins, held write goes in afterwards.
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'h14;
        bus.prog_data = 32'hDEADBEEF;
        start_read(6'h05);
        check("collide_prog_ready", 128'(bus.prog_ready), 128'(0));
        @(posedge clk); #1;
        bus.prog_data = 32'h12345678;
        #1;
        wait_resp(cyc, data);
        check("collide_read_cycles", 128'(cyc + 1), 128'(9));
        check("collide_read_data", data, 128'hA0000017_A0000016_A0000015_A0000014);
        check("retry_prog_ready", 128'(bus.prog_ready), 128'(1));
        @(posedge clk); #1;
        bus.prog_we = 1'b0;
        start_read(6'h05);
        wait_resp(cyc, data);
        check("retry_write_cycles", 128'(cyc), 128'(9));
        check("retry_write_data", data, 128'hA0000017_A0000016_A0000015_12345678);
        prog_write(8'h14, 32'hA0000014);

        // Reset asserted mid-WAIT.
        start_read(6'h05);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midwait_reset_busywait", 128'(bus.mem_busywait), 128'(0));
        check("midwait_reset_readdata", bus.mem_readdata, 128'h0);
        bus.mem_read = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_read(6'h05);
        wait_resp(cyc, data);
        check("post_reset_cycles", 128'(cyc), 128'(9));
        check("post_reset_data", data, 128'hA0000017_A0000016_A0000015_A0000014);

        // Repeat read of the same block, then write into it and read again.
        start_read(6'h05);
        wait_resp(cyc, data);
        check("repeat_cycles", 128'(cyc), 128'(lb_busy));
        check("repeat_data", data, 128'hA0000017_A0000016_A0000015_A0000014);
        prog_write(8'h14, 32'h55AA55AA);
        start_read(6'h05);
        wait_resp(cyc, data);
        check("rewrite_cycles", 128'(cyc), 128'(9));
        check("rewrite_data", data, 128'hA0000017_A0000016_A0000015_55AA55AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
